// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared constants for the I2C FIFO/status slice:
//   DATA_W      - byte width of the FIFO data path
//   FIFO_DEPTH  - default number of entries per FIFO
//   ST_*        - bit positions inside status_reg
//   STATUS_RST  - status_reg value straight out of reset (both FIFOs empty)
//   err_bits_t  - layout of the sticky error nibble status_reg[3:0]
// ----------------------------------------------------------------------------
package i2c_pkg;

   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;

   localparam int ST_TX_FULL  = 7;
   localparam int ST_TX_EMPTY = 6;
   localparam int ST_RX_FULL  = 5;
   localparam int ST_RX_EMPTY = 4;
   localparam int ST_TX_OVF   = 3;
   localparam int ST_RX_OVF   = 2;
   localparam int ST_TX_UNF   = 1;
   localparam int ST_RX_UNF   = 0;

   localparam logic [7:0] STATUS_RST = 8'h50;

   typedef struct packed {
      logic tx_ovf;
      logic rx_ovf;
      logic tx_unf;
      logic rx_unf;
   } err_bits_t;

endpackage : i2c_pkg

// File: rtl/i2c_sync_fifo.sv
// ----------------------------------------------------------------------------
// i2c_sync_fifo
// Single-clock show-ahead FIFO used for both the TX and RX byte paths.
// Ports:
//   PCLK, PRESET        clock and synchronous active-high reset
//   wr_en, wr_data      push strobe and byte
//   rd_en, rd_data      pop strobe and current head byte (0 while empty)
//   full, empty         occupancy flags derived from the registered pointers
//   ovf_pulse           push dropped because the FIFO was full with no pop
//   unf_pulse           pop requested while the FIFO was empty
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
// ----------------------------------------------------------------------------
module i2c_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic              ovf_pulse,
   output logic              unf_pulse
);

   localparam int              ADDR_W  = $clog2(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [ADDR_W:0]   wr_ptr_r;
   logic [ADDR_W:0]   rd_ptr_r;
   logic [ADDR_W:0]   count_s;
   logic              full_s;
   logic              empty_s;
   logic              push_s;
   logic              pop_s;
   logic [DATA_W-1:0] rd_data_s;
   logic [DATA_W-1:0] mem_r [DEPTH];

   // Occupancy, accepted strobes and error pulses from the registered pointers
   always_comb begin
      count_s = wr_ptr_r - rd_ptr_r;
      full_s  = (count_s == DEPTH_C);
      empty_s = (count_s == {(ADDR_W + 1){1'b0}});
      // A pop while full frees the slot the push lands in, so both proceed.
      push_s  = wr_en && (!full_s || rd_en);
      // Only an empty FIFO refuses a pop; a same-cycle push cannot feed it.
      pop_s   = rd_en && !empty_s;
      if (empty_s) begin
         rd_data_s = {DATA_W{1'b0}};
      end else begin
         rd_data_s = mem_r[rd_ptr_r[ADDR_W-1:0]];
      end
   end

   // Read and write pointers
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         wr_ptr_r <= {(ADDR_W + 1){1'b0}};
         rd_ptr_r <= {(ADDR_W + 1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   // Storage array; contents survive reset, the pointers make them invisible
   always_ff @(posedge PCLK) begin
      if (push_s && !PRESET) begin
         mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_data;
      end
   end

   assign rd_data   = rd_data_s;
   assign full      = full_s;
   assign empty     = empty_s;
   assign ovf_pulse = wr_en && full_s && !rd_en;
   assign unf_pulse = rd_en && empty_s;

endmodule : i2c_sync_fifo

// File: rtl/i2c_fifo_status.sv
// ----------------------------------------------------------------------------
// i2c_fifo_status
// TX and RX byte FIFOs between the APB register block and the I2C engine,
// plus the 8-bit status register read by APB.
// Ports:
//   PCLK, PRESET              clock and synchronous active-high reset
//   tx_wr_en, tx_wr_data      APB push into the TX FIFO
//   tx_rd_en, tx_rd_data      I2C engine pop / show-ahead TX head
//   rx_wr_en, rx_wr_data      I2C engine push into the RX FIFO
//   rx_rd_en, rx_rd_data      APB pop / show-ahead RX head
//   err_clr                   clears the sticky error nibble
//   status_reg                {TX_full, TX_empty, RX_full, RX_empty,
//                              TX_ovf, RX_ovf, TX_unf, RX_unf}
// ----------------------------------------------------------------------------
module i2c_fifo_status #(
   parameter int DATA_W = i2c_pkg::DATA_W,
   parameter int DEPTH  = i2c_pkg::FIFO_DEPTH
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              tx_wr_en,
   input  logic [DATA_W-1:0] tx_wr_data,
   input  logic              tx_rd_en,
   output logic [DATA_W-1:0] tx_rd_data,
   input  logic              rx_wr_en,
   input  logic [DATA_W-1:0] rx_wr_data,
   input  logic              rx_rd_en,
   output logic [DATA_W-1:0] rx_rd_data,
   input  logic              err_clr,
   output logic [7:0]        status_reg
);

   import i2c_pkg::*;

   logic      tx_full_s;
   logic      tx_empty_s;
   logic      tx_ovf_s;
   logic      tx_unf_s;
   logic      rx_full_s;
   logic      rx_empty_s;
   logic      rx_ovf_s;
   logic      rx_unf_s;
   err_bits_t err_set_s;
   err_bits_t err_r;
   logic [7:0] status_s;

   i2c_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_tx_fifo (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .wr_en     (tx_wr_en),
      .wr_data   (tx_wr_data),
      .rd_en     (tx_rd_en),
      .rd_data   (tx_rd_data),
      .full      (tx_full_s),
      .empty     (tx_empty_s),
      .ovf_pulse (tx_ovf_s),
      .unf_pulse (tx_unf_s)
   );

   i2c_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_rx_fifo (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .wr_en     (rx_wr_en),
      .wr_data   (rx_wr_data),
      .rd_en     (rx_rd_en),
      .rd_data   (rx_rd_data),
      .full      (rx_full_s),
      .empty     (rx_empty_s),
      .ovf_pulse (rx_ovf_s),
      .unf_pulse (rx_unf_s)
   );

   // Collect this cycle's error events in sticky-nibble order
   always_comb begin
      err_set_s.tx_ovf = tx_ovf_s;
      err_set_s.rx_ovf = rx_ovf_s;
      err_set_s.tx_unf = tx_unf_s;
      err_set_s.rx_unf = rx_unf_s;
   end

   // Sticky error bits: a new event wins over a same-cycle clear
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         err_r <= err_bits_t'(STATUS_RST[3:0]);
      end else if (err_clr) begin
         err_r <= err_set_s;
      end else begin
         err_r <= err_r | err_set_s;
      end
   end

   // Status register assembly from FIFO flags and sticky bits
   always_comb begin
      status_s              = 8'h00;
      status_s[ST_TX_FULL]  = tx_full_s;
      status_s[ST_TX_EMPTY] = tx_empty_s;
      status_s[ST_RX_FULL]  = rx_full_s;
      status_s[ST_RX_EMPTY] = rx_empty_s;
      status_s[ST_TX_OVF]   = err_r.tx_ovf;
      status_s[ST_RX_OVF]   = err_r.rx_ovf;
      status_s[ST_TX_UNF]   = err_r.tx_unf;
      status_s[ST_RX_UNF]   = err_r.rx_unf;
   end

   assign status_reg = status_s;

endmodule : i2c_fifo_status
